// File: rtl/mm2s_stream_framer_if.sv
// AXI4-Stream bundle used on both sides of mm2s_stream_framer.
// tuser is present only when FRAMER_TUSER_SOF_EN is defined.
interface mm2s_stream_framer_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
`ifdef FRAMER_TUSER_SOF_EN
  logic                tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
`else
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
`endif
endinterface

// File: rtl/mm2s_stream_framer.sv
// Re-frames MM2S read data into PKT_BYTES packets with regenerated tlast and a 2-entry skid buffer.
// Optional start-of-frame tuser flag is enabled by defining FRAMER_TUSER_SOF_EN.
module mm2s_stream_framer #(
  parameter int DATA_W    = 64,
  parameter int PKT_BYTES = 4096
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic                 start,
  input  logic [63:0]          data_size,
  mm2s_stream_framer_if.slave  s_axis,
  mm2s_stream_framer_if.master m_axis,
  output logic                 busy,
  output logic                 frame_done,
  output logic [63:0]          byte_cnt,
  output logic [31:0]          frame_cnt,
  output logic                 err_start
);

  localparam int BPB       = DATA_W / 8;
  localparam int PKT_BEATS = PKT_BYTES / BPB;
  localparam int PKT_W     = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  localparam logic [63:0]      BPB64    = 64'(BPB);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BPB-1:0]    keep;
    logic              last;
`ifdef FRAMER_TUSER_SOF_EN
    logic              sof;
`endif
  } beat_t;

  state_e            state_q, state_d;
  logic [63:0]       total_q, total_d;
  logic [63:0]       in_cnt_q, in_cnt_d;
  logic [PKT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  beat_t             out_q, out_d;
  logic              out_vld_q, out_vld_d;
  beat_t             skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic              s_rdy_q, s_rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [63:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;

  logic              in_hs;
  logic              out_hs;
  beat_t             in_beat;
  logic [63:0]       beats_div;
  logic [63:0]       beats_rem;
  logic [63:0]       beats_ceil;
  logic              unused_in;

`ifdef FRAMER_TUSER_SOF_EN
  assign unused_in = s_axis.tlast ^ s_axis.tuser;
`else
  assign unused_in = s_axis.tlast;
`endif

  always_comb begin
    in_hs  = s_axis.tvalid & s_rdy_q;
    out_hs = out_vld_q & m_axis.tready;

    beats_div  = data_size / BPB64;
    beats_rem  = data_size % BPB64;
    beats_ceil = beats_div + {63'd0, (beats_rem != '0)};

    in_beat      = '0;
    in_beat.data = s_axis.tdata;
    in_beat.keep = s_axis.tkeep;
    in_beat.last = (pkt_cnt_q == PKT_LAST) || (in_cnt_q == total_q - 64'd1);
`ifdef FRAMER_TUSER_SOF_EN
    in_beat.sof  = (in_cnt_q == '0);
`endif
  end

  // Output register refills from the skid entry first so beat order is preserved.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_hs) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_d      = in_beat;
        out_vld_d  = in_hs;
      end
    end else if (in_hs) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    in_cnt_d    = in_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    s_rdy_d     = 1'b0;

    if (out_hs) begin
      byte_cnt_d = byte_cnt_q + BPB64;
    end
    if (start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          total_d    = beats_ceil;
          in_cnt_d   = '0;
          pkt_cnt_d  = '0;
          byte_cnt_d = '0;
          // An empty frame passes through DRAIN so DONE lands two cycles after start.
          if (beats_ceil == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
            s_rdy_d = 1'b1;
          end
        end
      end
      RUN: begin
        s_rdy_d = !skid_vld_d;
        if (in_hs) begin
          in_cnt_d  = in_cnt_q + 64'd1;
          pkt_cnt_d = in_beat.last ? '0 : pkt_cnt_q + PKT_W'(1);
          if (in_cnt_q == total_q - 64'd1) begin
            state_d = DRAIN;
            s_rdy_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Look ahead at the buffer so frame_done follows the last handshake by one cycle.
        if (!skid_vld_d && !out_vld_d) begin
          state_d     = DONE;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      in_cnt_q    <= '0;
      pkt_cnt_q   <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      s_rdy_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      in_cnt_q    <= in_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      s_rdy_q     <= s_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign s_axis.tready = s_rdy_q;
  assign m_axis.tdata  = out_q.data;
  assign m_axis.tkeep  = out_q.keep;
  assign m_axis.tlast  = out_q.last;
  assign m_axis.tvalid = out_vld_q;
`ifdef FRAMER_TUSER_SOF_EN
  assign m_axis.tuser  = out_q.sof;
`endif

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign byte_cnt   = byte_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_start  = err_q;

endmodule

// File: tb/tb_mm2s_stream_framer.sv
// Directed bench for mm2s_stream_framer (DATA_W=64, PKT_BYTES=4096).
// The SOF test is compiled in when FRAMER_TUSER_SOF_EN is defined.
`timescale 1ns/1ps
module tb_mm2s_stream_framer;
  localparam int DATA_W    = 64;
  localparam int PKT_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] data_size = '0;
  logic        busy, frame_done, err_start;
  logic [63:0] byte_cnt;
  logic [31:0] frame_cnt;

  mm2s_stream_framer_if #(.DATA_W(DATA_W)) s_if ();
  mm2s_stream_framer_if #(.DATA_W(DATA_W)) m_if ();

  mm2s_stream_framer #(.DATA_W(DATA_W), .PKT_BYTES(PKT_BYTES)) dut (
    .axis_clk   (clk),
    .axis_rst   (rst),
    .start      (start),
    .data_size  (data_size),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .busy       (busy),
    .frame_done (frame_done),
    .byte_cnt   (byte_cnt),
    .frame_cnt  (frame_cnt),
    .err_start  (err_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  bit          cap_last[$];
  bit          cap_user[$];
  int          cap_cyc[$];
  int          done_cyc, done_cnt, stall_viol, valid_seen, src_acc, fin_cyc;
  bit          rdy_start, rdy_after_fin, busy_c1;

  function automatic logic [63:0] pat_data(input logic [31:0] base, input int idx);
    return {base, 32'(idx)};
  endfunction

  function automatic logic [7:0] pat_keep(input int idx);
    return 8'(idx) ^ 8'h5A;
  endfunction

  // Drives one frame (start in cycle 0) and records everything the sink sees.
  task automatic run_stream(input logic [63:0] size, input int vpct, input int rpct,
                            input int src_beats, input logic [31:0] base, input int err_at,
                            input int stop_beats, input int max_cyc);
    int src_idx, tail, tot;
    bit s_hs, prev_stall, pl;
    logic [63:0] pd;
    logic [7:0]  pk;
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_user.delete(); cap_cyc.delete();
    done_cyc = -1; done_cnt = 0; stall_viol = 0; valid_seen = 0; fin_cyc = -1;
    rdy_after_fin = 1'b1; busy_c1 = 1'b0;
    tot = int'((size + 64'd7) / 64'd8);
    src_idx = 0; tail = -1; s_hs = 0; prev_stall = 0; pd = '0; pk = '0; pl = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start     = (c == 0) || (c == err_at);
      data_size = (c == 0) ? size : 64'd64;
      s_if.tvalid = (src_idx < src_beats) &&
                    ((s_if.tvalid && !s_hs) || (int'($urandom_range(99)) < vpct));
      s_if.tdata  = pat_data(base, src_idx);
      s_if.tkeep  = pat_keep(src_idx);
      s_if.tlast  = (src_idx % 3 == 0);
      m_if.tready = (int'($urandom_range(99)) < rpct);
      if (c == 0) rdy_start = s_if.tready;
      if (c == 1) busy_c1 = busy;
      if (fin_cyc >= 0 && c == fin_cyc + 1) rdy_after_fin = s_if.tready;
      if (prev_stall && (!m_if.tvalid || m_if.tdata !== pd || m_if.tkeep !== pk || m_if.tlast !== pl))
        stall_viol++;
      prev_stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; pk = m_if.tkeep; pl = m_if.tlast;
      if (m_if.tvalid) valid_seen++;
      s_hs = s_if.tvalid && s_if.tready;
      if (s_hs) begin
        src_idx++;
        if (src_idx == tot) fin_cyc = c;
      end
      if (m_if.tvalid && m_if.tready) begin
        cap_data.push_back(m_if.tdata);
        cap_keep.push_back(m_if.tkeep);
        cap_last.push_back(m_if.tlast);
`ifdef FRAMER_TUSER_SOF_EN
        cap_user.push_back(m_if.tuser);
`endif
        cap_cyc.push_back(c);
      end
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      src_acc = src_idx;
      if (stop_beats > 0 && cap_data.size() == stop_beats) return;
      if (done_cyc >= 0 && tail < 0) tail = c + 3;
      if (c == tail) break;
    end
    @(negedge clk);
    start = 1'b0;
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b exp 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b exp 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got %b exp 0", m_if.tlast); end
    checks++; if (m_if.tdata !== 64'd0) begin errors++; $display("FAIL rst_m_tdata got %h exp 0", m_if.tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL rst_byte_cnt got %0d exp 0", byte_cnt); end
    checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (err_start !== 1'b0) begin errors++; $display("FAIL rst_err_start got %b exp 0", err_start); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_two_packets();
    int bubbles = 0;
    run_stream(64'd8192, 100, 100, 1100, 32'hA000_0001, -1, 0, 3000);
    checks++; if (cap_data.size() !== 1024) begin errors++; $display("FAIL two_pkt_count got %0d exp 1024", cap_data.size()); end
    foreach (cap_data[i]) begin
      checks++; if (cap_data[i] !== pat_data(32'hA000_0001, i)) begin errors++; $display("FAIL two_pkt_data[%0d] got %h exp %h", i, cap_data[i], pat_data(32'hA000_0001, i)); end
      checks++; if (cap_last[i] !== bit'(i == 511 || i == 1023)) begin errors++; $display("FAIL two_pkt_last[%0d] got %b exp %b", i, cap_last[i], (i == 511 || i == 1023)); end
      checks++; if (cap_keep[i] !== pat_keep(i)) begin errors++; $display("FAIL two_pkt_keep[%0d] got %h exp %h", i, cap_keep[i], pat_keep(i)); end
      if (i > 0 && cap_cyc[i] != cap_cyc[i-1] + 1) bubbles++;
    end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL two_pkt_bubbles got %0d exp 0", bubbles); end
    checks++; if (rdy_start !== 1'b0) begin errors++; $display("FAIL two_pkt_ready_at_start got %b exp 0", rdy_start); end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL two_pkt_busy got %b exp 1", busy_c1); end
    checks++; if (cap_cyc.size() == 0 || cap_cyc[0] !== 2) begin errors++; $display("FAIL two_pkt_first_beat_cycle got %0d exp 2", (cap_cyc.size() == 0) ? -1 : cap_cyc[0]); end
    checks++; if (done_cyc !== 1026) begin errors++; $display("FAIL two_pkt_done_cycle got %0d exp 1026", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL two_pkt_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (byte_cnt !== 64'd8192) begin errors++; $display("FAIL two_pkt_byte_cnt got %0d exp 8192", byte_cnt); end
    checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL two_pkt_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_pkt_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_partial();
    run_stream(64'd100, 100, 100, 20, 32'hB000_0002, -1, 0, 200);
    checks++; if (cap_data.size() !== 13) begin errors++; $display("FAIL partial_count got %0d exp 13", cap_data.size()); end
    foreach (cap_data[i]) begin
      checks++; if (cap_data[i] !== pat_data(32'hB000_0002, i)) begin errors++; $display("FAIL partial_data[%0d] got %h exp %h", i, cap_data[i], pat_data(32'hB000_0002, i)); end
      checks++; if (cap_last[i] !== bit'(i == 12)) begin errors++; $display("FAIL partial_last[%0d] got %b exp %b", i, cap_last[i], (i == 12)); end
    end
    checks++; if (src_acc !== 13) begin errors++; $display("FAIL partial_accepted got %0d exp 13", src_acc); end
    checks++; if (rdy_after_fin !== 1'b0) begin errors++; $display("FAIL partial_ready_after_last got %b exp 0", rdy_after_fin); end
    checks++; if (done_cyc !== 15) begin errors++; $display("FAIL partial_done_cycle got %0d exp 15", done_cyc); end
    checks++; if (byte_cnt !== 64'd104) begin errors++; $display("FAIL partial_byte_cnt got %0d exp 104", byte_cnt); end
    checks++; if (frame_cnt !== 32'd2) begin errors++; $display("FAIL partial_frame_cnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_empty();
    run_stream(64'd0, 100, 100, 4, 32'hC000_0003, -1, 0, 50);
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL empty_valid_cycles got %0d exp 0", valid_seen); end
    checks++; if (src_acc !== 0) begin errors++; $display("FAIL empty_accepted got %0d exp 0", src_acc); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL empty_done_cycle got %0d exp 2", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL empty_byte_cnt got %0d exp 0", byte_cnt); end
    checks++; if (frame_cnt !== 32'd3) begin errors++; $display("FAIL empty_frame_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    run_stream(64'd12288, 70, 50, 1600, 32'hD000_0004, -1, 0, 20000);
    checks++; if (cap_data.size() !== 1536) begin errors++; $display("FAIL bp_count got %0d exp 1536", cap_data.size()); end
    foreach (cap_data[i]) begin
      checks++; if (cap_data[i] !== pat_data(32'hD000_0004, i)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, cap_data[i], pat_data(32'hD000_0004, i)); end
      checks++; if (cap_last[i] !== bit'(i == 511 || i == 1023 || i == 1535)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, cap_last[i], (i == 511 || i == 1023 || i == 1535)); end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stability got %0d exp 0", stall_viol); end
    checks++; if (cap_cyc.size() == 0 || done_cyc !== cap_cyc[$] + 1) begin errors++; $display("FAIL bp_done_cycle got %0d exp last+1", done_cyc); end
    checks++; if (byte_cnt !== 64'd12288) begin errors++; $display("FAIL bp_byte_cnt got %0d exp 12288", byte_cnt); end
    checks++; if (frame_cnt !== 32'd4) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 4", frame_cnt); end
  endtask

  task automatic test_errors_reset();
    run_stream(64'd4096, 100, 100, 600, 32'hE000_0005, 50, 0, 2000);
    checks++; if (err_start !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_start); end
    checks++; if (cap_data.size() !== 512) begin errors++; $display("FAIL err_frame_len got %0d exp 512", cap_data.size()); end
    checks++; if (cap_data.size() == 512 && cap_last[511] !== 1'b1) begin errors++; $display("FAIL err_last got %b exp 1", cap_last[511]); end
    checks++; if (frame_cnt !== 32'd5) begin errors++; $display("FAIL err_frame_cnt got %0d exp 5", frame_cnt); end
    run_stream(64'd8192, 100, 100, 1100, 32'hE100_0006, -1, 300, 2000);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid got %b exp 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_s_tready got %b exp 0", s_if.tready); end
    checks++; if (err_start !== 1'b0) begin errors++; $display("FAIL midrst_err_start got %b exp 0", err_start); end
    checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL midrst_frame_cnt got %0d exp 0", frame_cnt); end
    rst = 1'b0;
    start = 1'b0;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    run_stream(64'd64, 100, 100, 8, 32'hF000_0007, -1, 0, 200);
    checks++; if (cap_data.size() !== 8) begin errors++; $display("FAIL post_rst_count got %0d exp 8", cap_data.size()); end
    foreach (cap_data[i]) begin
      checks++; if (cap_data[i] !== pat_data(32'hF000_0007, i)) begin errors++; $display("FAIL post_rst_data[%0d] got %h exp %h", i, cap_data[i], pat_data(32'hF000_0007, i)); end
      checks++; if (cap_last[i] !== bit'(i == 7)) begin errors++; $display("FAIL post_rst_last[%0d] got %b exp %b", i, cap_last[i], (i == 7)); end
    end
    checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL post_rst_frame_cnt got %0d exp 1", frame_cnt); end
  endtask

`ifdef FRAMER_TUSER_SOF_EN
  task automatic test_sof();
    for (int f = 0; f < 2; f++) begin
      run_stream(64'd4096, 100, 100, 512, 32'h5000_0000 + 32'(f), -1, 0, 2000);
      checks++; if (cap_user.size() !== 512) begin errors++; $display("FAIL sof_count[%0d] got %0d exp 512", f, cap_user.size()); end
      foreach (cap_user[i]) begin
        checks++; if (cap_user[i] !== bit'(i == 0)) begin errors++; $display("FAIL sof_tuser[%0d][%0d] got %b exp %b", f, i, cap_user[i], (i == 0)); end
      end
    end
    checks++; if (frame_cnt !== 32'd3) begin errors++; $display("FAIL sof_frame_cnt got %0d exp 3", frame_cnt); end
  endtask
`endif

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
`ifdef FRAMER_TUSER_SOF_EN
    s_if.tuser  = 1'b0;
`endif
    m_if.tready = 1'b0;
    test_reset();
    test_two_packets();
    test_partial();
    test_empty();
    test_backpressure();
    test_errors_reset();
`ifdef FRAMER_TUSER_SOF_EN
    test_sof();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
